ram_log_sequencer: RTL and testbench
====================================

// Module: ram_log_sequencer
// PURPOSE
//  Controller that sequences the ram_save logging BRAM: arms/runs capture until the BRAM reports full,
//  then dumps the stored words in address order to a downstream consumer over a valid/ready stream.
//  Drives ram_save's in_log_ram_run and in_ram_read_addr; consumes its full flag and read data.
//  Sits between the CPU/control registers and u_ram_save; the only owner of the BRAM control pins.
// PARAMETERS
//  NB_DATA          16      width of logged word / read data
//  NB_ADDR          10      BRAM address width; depth DEPTH = 2**NB_ADDR
//  NB_TIMEOUT       20      width of capture timeout counter
//  CAPTURE_TIMEOUT  1048575 max cycles in CAPTURE without full before error (must be < 2**NB_TIMEOUT)
// PORTS
//  clock              in   1        system clock
//  reset              in   1        synchronous, active-low reset
//  i_start_capture    in   1        1-cycle pulse: begin capture
//  i_start_dump       in   1        1-cycle pulse: begin dump
//  i_abort            in   1        return to IDLE from any state
//  i_ram_full         in   1        ram_save full flag
//  i_ram_data         in   NB_DATA  ram_save read data (1-cycle latency after address)
//  o_log_run          out  1        to ram_save in_log_ram_run
//  o_read_addr        out  NB_ADDR  to ram_save in_ram_read_addr
//  o_out_data         out  NB_DATA  dump stream data
//  o_out_valid        out  1        dump stream valid
//  i_out_ready        in   1        dump stream ready
//  o_out_last         out  1        marks word at address DEPTH-1
//  o_busy             out  1        high in any state but IDLE
//  o_done             out  1        1-cycle pulse: capture reached FULL, or dump finished
//  o_timeout_err      out  1        sticky; set on capture timeout, cleared by next i_start_capture
//  o_state            out  3        current state encoding (debug)
// BEHAVIOUR
//  Reset (reset==0 at posedge): state IDLE; all outputs 0, o_read_addr=0, timeout counter 0.
//  All outputs registered. States (3-bit): IDLE=0, CAPTURE=1, FULL=2, RD_ADDR=3, RD_WAIT=4, RD_SEND=5.
//  IDLE: i_start_capture -> CAPTURE (o_log_run=1 from next cycle, clears o_timeout_err, counter=0).
//    i_start_dump -> RD_ADDR with o_read_addr=0. Both same cycle: capture wins, dump dropped.
//  CAPTURE: o_log_run=1; counter increments each cycle. i_ram_full=1 -> FULL, o_log_run=0 next cycle,
//    o_done pulse. counter==CAPTURE_TIMEOUT-1 without full -> IDLE, o_log_run=0, o_timeout_err=1.
//    i_start_dump / i_start_capture ignored here.
//  FULL: idle-hold; i_start_dump -> RD_ADDR (addr=0); i_start_capture -> CAPTURE (new capture).
//  RD_ADDR: o_read_addr stable; -> RD_WAIT (BRAM latency cycle).
//  RD_WAIT: -> RD_SEND, latching i_ram_data into o_out_data, o_out_valid=1,
//    o_out_last = (o_read_addr==DEPTH-1).
//  RD_SEND: hold o_out_data/valid/last stable while i_out_ready==0 (no drop, no change).
//    On valid&&ready: o_out_valid=0 next cycle; if last -> IDLE, o_read_addr wraps to 0, o_done pulse;
//    else o_read_addr+1 -> RD_ADDR. Throughput: 1 word per 3 cycles with ready held high.
//  Address arithmetic modulo 2**NB_ADDR; exactly DEPTH words per dump, addr 0 first.
//  i_abort (highest priority after reset): any state -> IDLE next cycle; o_log_run=0, o_out_valid=0,
//    o_out_last=0, o_read_addr=0; no o_done; o_timeout_err keeps its value.
//  i_ram_full already high on entry to CAPTURE: FULL after one cycle of o_log_run (ram_save ignores run).
//  Pulses on start inputs while busy (other than listed) are dropped, never queued.
// STRUCTURE
//  Shared header ram_log_defs.vh: state localparams (ST_IDLE..ST_RD_SEND), state width 3.
//  Single module, no sub-module; timeout counter and FSM inline. ram_save instantiated by parent.
// TESTING (NB_ADDR=4 -> DEPTH=16 for speed; counter data source as in ram_save bench)
//  1 Reset held 5 cycles -> o_state=0, o_log_run=0, o_out_valid=0, o_read_addr=0, o_busy=0.
//  2 start_capture, full model asserts after 16 writes -> o_log_run high 16+ cycles, state 2, one o_done.
//  3 start_dump, ready=1 -> 16 beats, data = written counter values addr 0..15, o_out_last only on
//    beat 16, 48 cycles total, o_done then state 0, o_read_addr=0.
//  4 dump with ready toggling 1/0 each cycle -> same 16 values, no duplicates/drops, data stable while
//    valid&&!ready.
//  5 CAPTURE_TIMEOUT=50, full never asserts -> IDLE at cycle 50, o_timeout_err=1; next capture clears it.
//  6 i_abort mid-dump at beat 7 and mid-capture; start_capture+start_dump same cycle -> IDLE next
//    cycle, outputs cleared; simultaneous starts enter CAPTURE (state 1).

Source files
------------

// File: rtl/ram_log_sequencer_pkg.sv
// Shared definitions for the ram_save logging BRAM sequencer: state encoding and width.
package ram_log_sequencer_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_FULL    = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_RD_SEND = 3'd5
  } state_t;

endpackage

// File: rtl/ram_log_sequencer.sv
// Sequences the ram_save logging BRAM: runs capture until full, then dumps all DEPTH words
// in address order over a valid/ready stream. Sole owner of the BRAM run/read-address pins.
module ram_log_sequencer
  import ram_log_sequencer_pkg::*;
#(
  parameter int NB_DATA         = 16,
  parameter int NB_ADDR         = 10,
  parameter int NB_TIMEOUT      = 20,
  parameter int CAPTURE_TIMEOUT = 1048575
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_start_capture,
  input  logic               i_start_dump,
  input  logic               i_abort,
  input  logic               i_ram_full,
  input  logic [NB_DATA-1:0] i_ram_data,
  output logic               o_log_run,
  output logic [NB_ADDR-1:0] o_read_addr,
  output logic [NB_DATA-1:0] o_out_data,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic               o_out_last,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_timeout_err,
  output logic [2:0]         o_state
);

  localparam logic [NB_ADDR-1:0]    LAST_ADDR    = '1;
  localparam logic [NB_TIMEOUT-1:0] TIMEOUT_LAST = NB_TIMEOUT'(CAPTURE_TIMEOUT - 1);

  state_t                  state;
  logic [NB_TIMEOUT-1:0]   timeout_cnt;

  assign o_state = state;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= ST_IDLE;
      timeout_cnt   <= '0;
      o_log_run     <= 1'b0;
      o_read_addr   <= '0;
      o_out_data    <= '0;
      o_out_valid   <= 1'b0;
      o_out_last    <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_timeout_err <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (i_abort) begin
        // Abort leaves the sticky timeout flag and last dumped data untouched.
        state       <= ST_IDLE;
        o_log_run   <= 1'b0;
        o_out_valid <= 1'b0;
        o_out_last  <= 1'b0;
        o_read_addr <= '0;
        o_busy      <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (i_start_capture) begin
              state         <= ST_CAPTURE;
              o_log_run     <= 1'b1;
              o_timeout_err <= 1'b0;
              timeout_cnt   <= '0;
              o_busy        <= 1'b1;
            end else if (i_start_dump) begin
              state       <= ST_RD_ADDR;
              o_read_addr <= '0;
              o_busy      <= 1'b1;
            end
          end

          ST_CAPTURE: begin
            timeout_cnt <= timeout_cnt + 1'b1;
            if (i_ram_full) begin
              state     <= ST_FULL;
              o_log_run <= 1'b0;
              o_done    <= 1'b1;
            end else if (timeout_cnt == TIMEOUT_LAST) begin
              state         <= ST_IDLE;
              o_log_run     <= 1'b0;
              o_timeout_err <= 1'b1;
              o_busy        <= 1'b0;
            end
          end

          ST_FULL: begin
            if (i_start_capture) begin
              state         <= ST_CAPTURE;
              o_log_run     <= 1'b1;
              o_timeout_err <= 1'b0;
              timeout_cnt   <= '0;
            end else if (i_start_dump) begin
              state       <= ST_RD_ADDR;
              o_read_addr <= '0;
            end
          end

          ST_RD_ADDR: state <= ST_RD_WAIT;

          // BRAM read data is valid one cycle after the address was presented.
          ST_RD_WAIT: begin
            state       <= ST_RD_SEND;
            o_out_data  <= i_ram_data;
            o_out_valid <= 1'b1;
            o_out_last  <= (o_read_addr == LAST_ADDR);
          end

          ST_RD_SEND: begin
            if (i_out_ready) begin
              o_out_valid <= 1'b0;
              o_out_last  <= 1'b0;
              o_read_addr <= o_read_addr + 1'b1;
              if (o_out_last) begin
                state  <= ST_IDLE;
                o_done <= 1'b1;
                o_busy <= 1'b0;
              end else begin
                state <= ST_RD_ADDR;
              end
            end
          end

          default: begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ram_log_sequencer.sv
// Randomized bench for ram_log_sequencer with a behavioural ram_save model (DEPTH=16).
module tb_ram_log_sequencer;

  localparam int NB_DATA = 16;
  localparam int NB_ADDR = 4;
  localparam int DEPTH   = 16;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               start_capture = 1'b0;
  logic               start_dump = 1'b0;
  logic               abort = 1'b0;
  logic               ram_full;
  logic [NB_DATA-1:0] ram_data;
  logic               log_run;
  logic [NB_ADDR-1:0] read_addr;
  logic [NB_DATA-1:0] out_data;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic               out_last;
  logic               busy;
  logic               done;
  logic               timeout_err;
  logic [2:0]         state;

  int n_chk = 0;
  int n_bad = 0;

  // ram_save model controls
  logic               ram_clr = 1'b0;
  logic               full_en = 1'b1;
  logic [NB_DATA-1:0] base = '0;
  logic [4:0]         wr_ptr;
  logic [NB_DATA-1:0] mem [DEPTH];

  always #5 clock = ~clock;

  ram_log_sequencer #(
    .NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .NB_TIMEOUT(20), .CAPTURE_TIMEOUT(50)
  ) dut (
    .clock(clock), .reset(reset),
    .i_start_capture(start_capture), .i_start_dump(start_dump), .i_abort(abort),
    .i_ram_full(ram_full), .i_ram_data(ram_data),
    .o_log_run(log_run), .o_read_addr(read_addr),
    .o_out_data(out_data), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_last(out_last), .o_busy(busy), .o_done(done),
    .o_timeout_err(timeout_err), .o_state(state)
  );

  // ram_save model: writes base+address while run is high, registered full, 1-cycle read latency
  always @(posedge clock) begin
    ram_data <= mem[read_addr];
    if (ram_clr) begin
      wr_ptr   <= '0;
      ram_full <= 1'b0;
    end else if (log_run && !ram_full && wr_ptr < 5'd16) begin
      mem[wr_ptr[3:0]] <= base + {11'd0, wr_ptr};
      wr_ptr <= wr_ptr + 5'd1;
      if (full_en && wr_ptr == 5'd15) ram_full <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic clear_ram();
    ram_clr = 1'b1;
    @(negedge clock);
    ram_clr = 1'b0;
    @(negedge clock);
  endtask

  task automatic run_capture(input string tag, input int exp_state, input int run_min,
                             input int run_max, input int exp_done, input int exp_err);
    int run_cnt;
    int done_cnt;
    bit fin;
    run_cnt = 0; done_cnt = 0; fin = 1'b0;
    start_capture = 1'b1;
    @(negedge clock);
    start_capture = 1'b0;
    for (int k = 0; k < 200 && !fin; k++) begin
      if (log_run) run_cnt++;
      if (done) done_cnt++;
      if (state != 3'd1) fin = 1'b1;
      else @(negedge clock);
    end
    @(negedge clock);
    if (done) done_cnt++;
    chk({tag, "_finished"}, 32'(fin), 32'd1);
    chk({tag, "_state"}, 32'(state), 32'(exp_state));
    chk({tag, "_run_in_range"}, 32'(run_cnt >= run_min && run_cnt <= run_max), 32'd1);
    chk({tag, "_done_pulses"}, 32'(done_cnt), 32'(exp_done));
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'(exp_err));
    chk({tag, "_log_run_off"}, 32'(log_run), 32'd0);
  endtask

  // mode 0: ready high, 1: ready toggles, 2: random ready; abort_beat<0 disables abort
  task automatic run_dump(input string tag, input int mode, input int abort_beat,
                          input logic [NB_DATA-1:0] b);
    int beats;
    int busy_cnt;
    int done_cnt;
    int unstable;
    bit hold;
    bit fin;
    bit aborted;
    logic [NB_DATA-1:0] hd;
    logic hl;
    beats = 0; busy_cnt = 0; done_cnt = 0; unstable = 0;
    hold = 1'b0; fin = 1'b0; aborted = 1'b0; hd = '0; hl = 1'b0;
    start_dump = 1'b1;
    @(negedge clock);
    start_dump = 1'b0;
    for (int k = 0; k < 800 && !fin; k++) begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (hold && (!out_valid || out_data !== hd || out_last !== hl)) unstable++;
      if (!busy) fin = 1'b1;
      else if (abort_beat >= 0 && beats == abort_beat && out_valid) begin
        abort = 1'b1;
        out_ready = 1'b0;
        aborted = 1'b1;
        fin = 1'b1;
        @(negedge clock);
        abort = 1'b0;
      end else begin
        case (mode)
          0:       out_ready = 1'b1;
          1:       out_ready = (k % 2 == 0);
          default: out_ready = 1'($urandom_range(0, 1));
        endcase
        hold = out_valid && !out_ready;
        hd = out_data;
        hl = out_last;
        if (out_valid && out_ready) begin
          chk({tag, "_data"}, 32'(out_data), 32'(b + NB_DATA'(beats)));
          chk({tag, "_last"}, 32'(out_last), 32'(beats == DEPTH - 1));
          beats++;
        end
        @(negedge clock);
      end
    end
    out_ready = 1'b0;
    chk({tag, "_stable_while_stalled"}, 32'(unstable), 32'd0);
    if (aborted) begin
      chk({tag, "_abort_beats"}, 32'(beats), 32'(abort_beat));
      chk({tag, "_abort_state"}, 32'(state), 32'd0);
      chk({tag, "_abort_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_abort_last"}, 32'(out_last), 32'd0);
      chk({tag, "_abort_addr"}, 32'(read_addr), 32'd0);
      chk({tag, "_abort_busy"}, 32'(busy), 32'd0);
      chk({tag, "_abort_no_done"}, 32'(done_cnt + int'(done)), 32'd0);
    end else begin
      chk({tag, "_finished"}, 32'(fin), 32'd1);
      chk({tag, "_beats"}, 32'(beats), 32'(DEPTH));
      chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
      chk({tag, "_state"}, 32'(state), 32'd0);
      chk({tag, "_addr_wrapped"}, 32'(read_addr), 32'd0);
      if (mode == 0) chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(3 * DEPTH));
      @(negedge clock);
      chk({tag, "_done_dropped"}, 32'(done), 32'd0);
    end
  endtask

  initial begin
    logic [NB_DATA-1:0] b1;
    logic [NB_DATA-1:0] b2;

    // reset held 5 cycles
    repeat (5) @(negedge clock);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_log_run", 32'(log_run), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_addr", 32'(read_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(timeout_err), 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // capture then dumps under different ready patterns
    b1 = NB_DATA'($urandom);
    base = b1;
    full_en = 1'b1;
    clear_ram();
    run_capture("cap", 2, 16, 18, 1, 0);
    run_dump("dump_rdy", 0, -1, b1);
    run_dump("dump_tog", 1, -1, b1);
    run_dump("dump_rnd", 2, -1, b1);

    // full still high on entry: single run cycle, contents untouched
    base = NB_DATA'($urandom);
    run_capture("cap_prefull", 2, 1, 1, 1, 0);
    run_dump("dump_prefull", 2, -1, b1);

    // timeout: full never asserts
    b2 = NB_DATA'($urandom);
    base = b2;
    full_en = 1'b0;
    clear_ram();
    run_capture("cap_tmo", 0, 50, 50, 0, 1);

    // abort mid-dump keeps sticky error
    run_dump("dump_abort", 2, 7, b2);
    chk("abort_keeps_err", 32'(timeout_err), 32'd1);

    // new capture clears error; abort mid-capture
    full_en = 1'b1;
    clear_ram();
    start_capture = 1'b1;
    @(negedge clock);
    start_capture = 1'b0;
    chk("recap_err_cleared", 32'(timeout_err), 32'd0);
    chk("recap_state", 32'(state), 32'd1);
    repeat (5) @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("cap_abort_state", 32'(state), 32'd0);
    chk("cap_abort_log_run", 32'(log_run), 32'd0);
    chk("cap_abort_busy", 32'(busy), 32'd0);
    chk("cap_abort_done", 32'(done), 32'd0);

    // simultaneous starts: capture wins
    start_capture = 1'b1;
    start_dump = 1'b1;
    @(negedge clock);
    start_capture = 1'b0;
    start_dump = 1'b0;
    chk("both_state", 32'(state), 32'd1);
    chk("both_log_run", 32'(log_run), 32'd1);
    chk("both_addr", 32'(read_addr), 32'd0);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("both_abort_state", 32'(state), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
